// File: rtl/hazard_pkg.sv
// Shared opcode constants and stage-select encoding for the load-use hazard detector.
package hazard_pkg;

    localparam logic [6:0] LOAD_OP = 7'b0000011;
    localparam logic [6:0] NOP_OP  = 7'b0000000;

    typedef enum logic [1:0] {
        SEL_FETCH  = 2'b00,
        SEL_DECODE = 2'b01,
        SEL_EXEC   = 2'b10,
        SEL_MEM    = 2'b11
    } stage_sel_t;

endpackage

// File: rtl/hazard_cond.sv
// Combinational load-use hazard condition: classifies stage opcodes and forms next-stall.
module hazard_cond
    import hazard_pkg::*;
#(
    parameter logic [6:0] LoadOp = LOAD_OP,
    parameter logic [6:0] NopOp  = NOP_OP
) (
    input  logic [1:0] sel_i,
    input  logic [6:0] fetch_i,
    input  logic [6:0] decode_i,
    input  logic [6:0] exec_i,
    input  logic [6:0] mem_i,
    output logic       stall_d_o
);

    function automatic logic is_load(input logic [6:0] op);
        return op == LoadOp;
    endfunction

    // Loads are excluded so back-to-back loads never stall.
    function automatic logic is_consumer(input logic [6:0] op);
        return (op != NopOp) && (op != LoadOp);
    endfunction

    // Fetch opcode never participates in a hazard check.
    logic unused_fetch;
    assign unused_fetch = ^fetch_i;

    stage_sel_t sel;
    assign sel = stage_sel_t'(sel_i);

    always_comb begin
        stall_d_o = 1'b0;
        unique case (sel)
            SEL_FETCH:  stall_d_o = 1'b0;
            SEL_DECODE: stall_d_o = is_load(exec_i) && is_consumer(decode_i);
            SEL_EXEC:   stall_d_o = is_load(exec_i)
                                    && (is_consumer(decode_i) || is_consumer(mem_i));
            SEL_MEM:    stall_d_o = is_load(mem_i) && is_consumer(decode_i);
            default:    stall_d_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use hazard detector: registered stall request with synchronous active-high reset.
module hazard_unit #(
    parameter logic [6:0] LOAD_OP = hazard_pkg::LOAD_OP,
    parameter logic [6:0] NOP_OP  = hazard_pkg::NOP_OP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] pipeline_state,
    input  logic [6:0] fetch,
    input  logic [6:0] decode,
    input  logic [6:0] exec,
    input  logic [6:0] mem,
    output logic       stall
);

    logic stall_d;
    logic stall_q;

    hazard_cond #(
        .LoadOp(LOAD_OP),
        .NopOp (NOP_OP)
    ) u_hazard_cond (
        .sel_i    (pipeline_state),
        .fetch_i  (fetch),
        .decode_i (decode),
        .exec_i   (exec),
        .mem_i    (mem),
        .stall_d_o(stall_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed plan plus randomized opcodes vs. a table-driven model.
module tb_hazard_unit;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] NOP = 7'b0000000;
    localparam logic [6:0] ALU = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] pipeline_state = 2'b00;
    logic [6:0] fetch = '0;
    logic [6:0] decode = '0;
    logic [6:0] exec = '0;
    logic [6:0] mem = '0;
    logic       stall;

    int total = 0;
    int bad   = 0;

    logic  exp_q[$];
    string tag_q[$];

    hazard_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pipeline_state(pipeline_state),
        .fetch         (fetch),
        .decode        (decode),
        .exec          (exec),
        .mem           (mem),
        .stall         (stall)
    );

    always #5 clk = ~clk;

    // Reference: per select, which stage must hold the load and which stages are
    // checked for consumers (bit i = stage i: 0 fetch, 1 decode, 2 exec, 3 mem).
    function automatic logic model(input logic r, input logic [1:0] s, input logic [6:0] f,
                                   input logic [6:0] d, input logic [6:0] e, input logic [6:0] m);
        logic [6:0] ops[4];
        int         load_stage;
        logic [3:0] cons_mask;
        logic       any_cons;
        ops[0] = f; ops[1] = d; ops[2] = e; ops[3] = m;
        case (s)
            2'd1:    begin load_stage = 2;  cons_mask = 4'b0010; end
            2'd2:    begin load_stage = 2;  cons_mask = 4'b1010; end
            2'd3:    begin load_stage = 3;  cons_mask = 4'b0010; end
            default: begin load_stage = -1; cons_mask = 4'b0000; end
        endcase
        if (r || load_stage < 0) return 1'b0;
        if (ops[load_stage] != LD) return 1'b0;
        any_cons = 1'b0;
        for (int i = 0; i < 4; i++)
            if (cons_mask[i] && ops[i] != NOP && ops[i] != LD) any_cons = 1'b1;
        return any_cons;
    endfunction

    task automatic drive(input string tag, input logic r, input logic [1:0] s,
                         input logic [6:0] f, input logic [6:0] d,
                         input logic [6:0] e, input logic [6:0] m);
        @(negedge clk);
        rst = r; pipeline_state = s; fetch = f; decode = d; exec = e; mem = m;
        exp_q.push_back(model(r, s, f, d, e, m));
        tag_q.push_back(tag);
    endtask

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return NOP;
            1:       return LD;
            2:       return ALU;
            default: return 7'($urandom);
        endcase
    endfunction

    // Monitor: each captured edge produces one registered result to check.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            total++;
            if (stall !== e) begin
                bad++;
                $display("FAIL %s: stall got %b expected %b at %0t", t, stall, e, $time);
            end
        end
    end

    initial begin
        // Reset held with a decode hazard present, then released.
        drive("rst_hold0", 1'b1, 2'b01, NOP, ALU, LD, NOP);
        drive("rst_hold1", 1'b1, 2'b01, NOP, ALU, LD, NOP);
        drive("rst_hold2", 1'b1, 2'b01, NOP, ALU, LD, NOP);
        drive("rst_release", 1'b0, 2'b01, NOP, ALU, LD, NOP);
        // Reset asserted mid-stall.
        drive("mid_rst", 1'b1, 2'b01, NOP, ALU, LD, NOP);
        drive("mid_rst_hold", 1'b1, 2'b01, NOP, ALU, LD, NOP);
        // Fetch select ignores everything.
        drive("fetch_zero", 1'b0, 2'b00, NOP, NOP, NOP, NOP);
        drive("fetch_haz", 1'b0, 2'b00, ALU, ALU, LD, NOP);
        // Decode select.
        drive("dec_haz", 1'b0, 2'b01, NOP, ALU, LD, NOP);
        drive("dec_nop", 1'b0, 2'b01, NOP, NOP, LD, NOP);
        // Execute select.
        drive("exe_haz", 1'b0, 2'b10, NOP, ALU, LD, ALU);
        drive("exe_noload", 1'b0, 2'b10, NOP, ALU, NOP, ALU);
        drive("exe_mem_only", 1'b0, 2'b10, NOP, NOP, LD, ALU);
        // Memory select.
        drive("mem_haz", 1'b0, 2'b11, NOP, ALU, NOP, LD);
        drive("mem_to_fetch", 1'b0, 2'b00, NOP, ALU, NOP, NOP);
        drive("mem_cons_mem", 1'b0, 2'b11, NOP, NOP, ALU, LD);
        // Load followed by load.
        drive("load_load", 1'b0, 2'b01, NOP, LD, LD, NOP);
        drive("dec_load_in_mem", 1'b0, 2'b01, NOP, ALU, NOP, LD);
        drive("near_load", 1'b0, 2'b01, NOP, ALU, 7'b1000011, NOP);

        for (int i = 0; i < 400; i++) begin
            drive("random", ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                  rand_op(), rand_op(), rand_op(), rand_op());
        end
        drive("final_idle", 1'b0, 2'b00, NOP, NOP, NOP, NOP);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d results left unchecked, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
